// File: rtl/scarv_cop_mem_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : scarv_cop_mem_seq_if / scarv_cop_mem_if
//  Brief    : Requester-side batch bus and COP memory port bundles.
//  Revision : 1.0
// ============================================================================

interface scarv_cop_mem_seq_if;
    logic         seq_req;
    logic         seq_ready;
    logic [3:0]   seq_cen;
    logic [3:0]   seq_wen;
    logic [127:0] seq_addr;
    logic [127:0] seq_wdata;
    logic [15:0]  seq_ben;
    logic         seq_abort;
    logic         seq_rsp;
    logic         seq_rsp_ack;
    logic [1:0]   seq_result;
    logic [1:0]   seq_err_lane;
    logic [127:0] seq_rdata;

    // master = requester (execute stage), slave = sequencer
    modport master (
        output seq_req, seq_cen, seq_wen, seq_addr, seq_wdata, seq_ben,
               seq_abort, seq_rsp_ack,
        input  seq_ready, seq_rsp, seq_result, seq_err_lane, seq_rdata
    );
    modport slave (
        input  seq_req, seq_cen, seq_wen, seq_addr, seq_wdata, seq_ben,
               seq_abort, seq_rsp_ack,
        output seq_ready, seq_rsp, seq_result, seq_err_lane, seq_rdata
    );
endinterface

interface scarv_cop_mem_if;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_mem_rdata;
    logic        cop_mem_stall;
    logic        cop_mem_error;

    // master = sequencer, slave = memory
    modport master (
        output cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben,
        input  cop_mem_rdata, cop_mem_stall, cop_mem_error
    );
    modport slave (
        input  cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben,
        output cop_mem_rdata, cop_mem_stall, cop_mem_error
    );
endinterface

`default_nettype wire

// File: rtl/scarv_cop_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module   : scarv_cop_mem_seq
//  Brief    : Issues up to four scatter/gather lanes in ascending order on the
//             single COP memory port and returns read data plus one status.
//             Optional: SCARV_COP_MEM_SEQ_ALIGN_CHECK_EN enables misalign check.
//  Revision : 1.0
// ============================================================================

module scarv_cop_mem_seq #(
    parameter int          NLANES    = 4,
    parameter logic [31:0] RST_RDATA = 32'h0
) (
    input  wire logic          g_clk,
    input  wire logic          g_reset,
    scarv_cop_mem_seq_if.slave seq,
    scarv_cop_mem_if.master    mem
);

    localparam int         c_W            = NLANES * 32;
    localparam logic [1:0] c_RES_OK       = 2'b00;
    localparam logic [1:0] c_RES_BUSERR   = 2'b01;
    localparam logic [1:0] c_RES_MISALIGN = 2'b10;
    localparam logic [1:0] c_RES_ABORT    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NLANES-1:0]   r_mask;
    logic [NLANES-1:0]   r_wen;
    logic [c_W-1:0]      r_addr;
    logic [c_W-1:0]      r_wdata;
    logic [c_W-1:0]      r_rdata;
    logic [NLANES*4-1:0] r_ben;
    logic [1:0]          r_cur;
    logic [1:0]          r_result;
    logic [1:0]          r_err_lane;
    logic                r_abort_pend;

    logic                w_issue;
    logic                w_accept;
    logic                w_abort;
    logic                w_misalign;
    logic [NLANES-1:0]   w_mask_clr;
    logic [1:0]          w_cur_next;
    logic [1:0]          w_result_next;
    logic [1:0]          w_err_next;
    logic [29:0]         w_lane_addr_hi;
    logic [31:0]         w_lane_wdata;
    logic [3:0]          w_lane_ben;

    function automatic logic [1:0] f_lowest(input logic [NLANES-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign w_lane_addr_hi = r_addr[{r_cur, 5'd2} +: 30];
    assign w_lane_wdata   = r_wdata[{r_cur, 5'd0} +: 32];
    assign w_lane_ben     = r_ben[{r_cur, 2'd0} +: 4];
    assign w_mask_clr     = r_mask & ~(NLANES'(1) << r_cur);
    // An abort raised in the accept cycle itself still counts.
    assign w_abort        = r_abort_pend | seq.seq_abort;

`ifdef SCARV_COP_MEM_SEQ_ALIGN_CHECK_EN
    logic [1:0] w_off;
    assign w_off      = r_addr[{r_cur, 5'd0} +: 2];
    assign w_misalign = (r_state == S_ISSUE) &&
                        (((w_lane_ben & ~(4'hF << w_off)) != 4'h0) ||
                         ((w_off != 2'b00) && (w_lane_ben == 4'hF)));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_accept      = 1'b0;
        w_cur_next    = r_cur;
        w_result_next = r_result;
        w_err_next    = r_err_lane;
        case (r_state)
            S_IDLE: begin
                if (seq.seq_req) begin
                    w_result_next = c_RES_OK;
                    w_err_next    = 2'd0;
                    w_cur_next    = f_lowest(seq.seq_cen);
                    w_state_next  = (seq.seq_cen == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_misalign) begin
                    w_result_next = c_RES_MISALIGN;
                    w_err_next    = r_cur;
                    w_state_next  = S_DONE;
                end else begin
                    w_issue = 1'b1;
                    if (!mem.cop_mem_stall) begin
                        w_accept = 1'b1;
                        if (mem.cop_mem_error) begin
                            w_result_next = c_RES_BUSERR;
                            w_err_next    = r_cur;
                            w_state_next  = S_DONE;
                        end else if (w_abort) begin
                            w_result_next = c_RES_ABORT;
                            w_err_next    = (w_mask_clr != '0) ? f_lowest(w_mask_clr) : r_cur;
                            w_state_next  = S_DONE;
                        end else if (w_mask_clr == '0) begin
                            w_state_next  = S_DONE;
                        end else begin
                            w_cur_next    = f_lowest(w_mask_clr);
                        end
                    end
                end
            end
            S_DONE: begin
                if (seq.seq_rsp_ack) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_mask       <= '0;
            r_wen        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ben        <= '0;
            r_rdata      <= {NLANES{RST_RDATA}};
            r_cur        <= 2'd0;
            r_result     <= c_RES_OK;
            r_err_lane   <= 2'd0;
            r_abort_pend <= 1'b0;
        end else begin
            r_cur      <= w_cur_next;
            r_result   <= w_result_next;
            r_err_lane <= w_err_next;
            if ((r_state == S_IDLE) && seq.seq_req) begin
                r_mask       <= seq.seq_cen;
                r_wen        <= seq.seq_wen;
                r_addr       <= seq.seq_addr;
                r_wdata      <= seq.seq_wdata;
                r_ben        <= seq.seq_ben;
                r_rdata      <= {NLANES{RST_RDATA}};
                r_abort_pend <= 1'b0;
            end
            if ((r_state == S_ISSUE) && seq.seq_abort) r_abort_pend <= 1'b1;
            if (w_accept && !mem.cop_mem_error) begin
                r_mask <= w_mask_clr;
                if (!r_wen[r_cur]) r_rdata[{r_cur, 5'd0} +: 32] <= mem.cop_mem_rdata;
            end
        end
    end

    assign seq.seq_ready    = (r_state == S_IDLE);
    assign seq.seq_rsp      = (r_state == S_DONE);
    assign seq.seq_result   = r_result;
    assign seq.seq_err_lane = r_err_lane;
    assign seq.seq_rdata    = r_rdata;

    // Bus outputs depend only on registered state, so they hold during stalls.
    assign mem.cop_mem_cen   = w_issue;
    assign mem.cop_mem_wen   = w_issue & r_wen[r_cur];
    assign mem.cop_mem_addr  = w_issue ? {w_lane_addr_hi, 2'b00} : 32'h0;
    assign mem.cop_mem_wdata = w_issue ? w_lane_wdata : 32'h0;
    assign mem.cop_mem_ben   = w_issue ? w_lane_ben : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_scarv_cop_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scarv_cop_mem_seq
//  Brief    : Directed plus random batches against a lane-level reference model.
//  Revision : 1.0
// ============================================================================

module tb_scarv_cop_mem_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scarv_cop_mem_seq_if sif ();
    scarv_cop_mem_if     mif ();

    scarv_cop_mem_seq #(
        .NLANES    (4),
        .RST_RDATA (32'h0)
    ) dut (
        .g_clk   (clk),
        .g_reset (rst),
        .seq     (sif),
        .mem     (mif)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  b_cen, b_wen;
    logic [31:0] b_addr [4];
    logic [31:0] b_wdata[4];
    logic [31:0] b_mval [4];
    logic [3:0]  b_ben  [4];
    int          b_stall[4];
    int          b_err_lane, b_abort_lane, b_ack_delay;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit misaligned(input logic [31:0] a, input logic [3:0] be);
        bit m;
        m = 1'b0;
`ifdef SCARV_COP_MEM_SEQ_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00 && be == 4'hF) m = 1'b1;
        for (int b = 0; b < 4; b++)
            if (be[b] && b < int'(a[1:0])) m = 1'b1;
`else
        if (a === 32'hx && be === 4'hx) m = 1'b0;
`endif
        return m;
    endfunction

    task automatic clear_batch();
        b_cen = 4'h0; b_wen = 4'h0;
        for (int i = 0; i < 4; i++) begin
            b_addr[i] = 32'h0; b_wdata[i] = 32'h0; b_mval[i] = 32'h0;
            b_ben[i] = 4'hF; b_stall[i] = 0;
        end
        b_err_lane = -1; b_abort_lane = -1; b_ack_delay = 0;
    endtask

    task automatic run_batch(input string nm);
        int          issued[$];
        logic [1:0]  e_res, e_err;
        logic [127:0] e_rdata;
        int          e_cen, e_lat, cen_seen, cyc, idx, lane, stall_left;
        bit          e_mis, first_stall;

        // Reference model: walk active lanes in ascending order.
        e_res = 2'd0; e_err = 2'd0; e_rdata = '0; e_cen = 0; e_mis = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!b_cen[i]) continue;
            if (misaligned(b_addr[i], b_ben[i])) begin
                e_res = 2'd2; e_err = 2'(i); e_mis = 1'b1; break;
            end
            issued.push_back(i);
            e_cen += b_stall[i] + 1;
            if (i == b_err_lane) begin e_res = 2'd1; e_err = 2'(i); break; end
            if (!b_wen[i]) e_rdata[32*i +: 32] = b_mval[i];
            if (i == b_abort_lane) begin
                e_res = 2'd3; e_err = 2'(i);
                for (int j = 3; j > i; j--) if (b_cen[j]) e_err = 2'(j);
                break;
            end
        end
        e_lat = e_cen + 1 + (e_mis ? 1 : 0);

        @(negedge clk);
        chk({nm, "_ready"}, sif.seq_ready, 1'b1);
        sif.seq_req = 1'b1; sif.seq_cen = b_cen; sif.seq_wen = b_wen;
        for (int i = 0; i < 4; i++) begin
            sif.seq_addr[32*i +: 32]  = b_addr[i];
            sif.seq_wdata[32*i +: 32] = b_wdata[i];
            sif.seq_ben[4*i +: 4]     = b_ben[i];
        end
        @(negedge clk);
        sif.seq_req = 1'b0;
        cyc = 1; idx = 0; cen_seen = 0; first_stall = 1'b1;
        stall_left = (issued.size() > 0) ? b_stall[issued[0]] : 0;
        while (!sif.seq_rsp && cyc < 200) begin
            mif.cop_mem_stall = 1'b0; mif.cop_mem_error = 1'b0;
            mif.cop_mem_rdata = $urandom; sif.seq_abort = 1'b0;
            if (mif.cop_mem_cen) begin
                cen_seen++;
                if (idx >= issued.size()) begin
                    chk({nm, "_extra_cen"}, mif.cop_mem_cen, 1'b0);
                end else begin
                    lane = issued[idx];
                    chk({nm, "_addr"},  mif.cop_mem_addr,  {b_addr[lane][31:2], 2'b00});
                    chk({nm, "_wen"},   mif.cop_mem_wen,   b_wen[lane]);
                    chk({nm, "_wdata"}, mif.cop_mem_wdata, b_wdata[lane]);
                    chk({nm, "_ben"},   mif.cop_mem_ben,   b_ben[lane]);
                    if (stall_left > 0) begin
                        mif.cop_mem_stall = 1'b1;
                        stall_left--;
                        if (first_stall && lane == b_abort_lane) sif.seq_abort = 1'b1;
                        first_stall = 1'b0;
                    end else begin
                        mif.cop_mem_error = (lane == b_err_lane);
                        mif.cop_mem_rdata = b_mval[lane];
                        idx++;
                        first_stall = 1'b1;
                        if (idx < issued.size()) stall_left = b_stall[issued[idx]];
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        mif.cop_mem_stall = 1'b0; mif.cop_mem_error = 1'b0; sif.seq_abort = 1'b0;

        chk({nm, "_rsp"},       sif.seq_rsp, 1'b1);
        chk({nm, "_latency"},   cyc, e_lat);
        chk({nm, "_cen_count"}, cen_seen, e_cen);
        chk({nm, "_result"},    sif.seq_result, e_res);
        chk({nm, "_err_lane"},  sif.seq_err_lane, e_err);
        chk({nm, "_rdata"},     sif.seq_rdata, e_rdata);
        chk({nm, "_done_cen"},  mif.cop_mem_cen, 1'b0);
        chk({nm, "_done_rdy"},  sif.seq_ready, 1'b0);
        for (int k = 0; k < b_ack_delay; k++) begin
            @(negedge clk);
            chk({nm, "_rsp_hold"}, sif.seq_rsp, 1'b1);
            chk({nm, "_res_hold"}, sif.seq_result, e_res);
        end
        sif.seq_rsp_ack = 1'b1;
        @(negedge clk);
        sif.seq_rsp_ack = 1'b0;
        chk({nm, "_ack_ready"}, sif.seq_ready, 1'b1);
        chk({nm, "_ack_rsp"},   sif.seq_rsp, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        sif.seq_req = 1'b0; sif.seq_cen = '0; sif.seq_wen = '0; sif.seq_addr = '0;
        sif.seq_wdata = '0; sif.seq_ben = '0; sif.seq_abort = 1'b0; sif.seq_rsp_ack = 1'b0;
        mif.cop_mem_rdata = '0; mif.cop_mem_stall = 1'b0; mif.cop_mem_error = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready",  sif.seq_ready, 1'b1);
        chk("rst_rsp",    sif.seq_rsp, 1'b0);
        chk("rst_result", sif.seq_result, 2'b00);
        chk("rst_err",    sif.seq_err_lane, 2'b00);
        chk("rst_rdata",  sif.seq_rdata, 128'h0);
        chk("rst_cen",    mif.cop_mem_cen, 1'b0);
        chk("rst_bus",    {mif.cop_mem_wen, mif.cop_mem_addr, mif.cop_mem_wdata, mif.cop_mem_ben}, 69'h0);

        // Three reads, lane 2 inactive
        clear_batch();
        b_cen = 4'b1011;
        b_addr[0] = 32'h100; b_addr[1] = 32'h104; b_addr[2] = 32'h108; b_addr[3] = 32'h10C;
        b_mval[0] = 32'hA0;  b_mval[1] = 32'hA1;  b_mval[2] = 32'hA2;  b_mval[3] = 32'hA3;
        run_batch("reads3");

        clear_batch();
        run_batch("empty");

        // Two stores, lane 0 stalled three cycles
        clear_batch();
        b_cen = 4'b0011; b_wen = 4'b0011; b_stall[0] = 3;
        b_addr[0] = 32'h2000; b_addr[1] = 32'h2004;
        b_wdata[0] = 32'hDEAD_BEEF; b_wdata[1] = 32'h1234_5678;
        b_ben[0] = 4'h3; b_ben[1] = 4'hC;
        run_batch("stores");

        // Bus error on lane 2
        clear_batch();
        b_cen = 4'hF; b_err_lane = 2;
        for (int i = 0; i < 4; i++) begin b_addr[i] = 32'h300 + 4*i; b_mval[i] = 32'hB0 + i; end
        run_batch("buserr");

        // Abort during stalled lane 1, response held 5 cycles
        clear_batch();
        b_cen = 4'hF; b_stall[1] = 2; b_abort_lane = 1; b_ack_delay = 5;
        for (int i = 0; i < 4; i++) begin b_addr[i] = 32'h400 + 4*i; b_mval[i] = 32'hC0 + i; end
        run_batch("abort");

        // Reset in the middle of a stalled batch
        @(negedge clk);
        sif.seq_req = 1'b1; sif.seq_cen = 4'hF; sif.seq_wen = 4'h0;
        @(negedge clk);
        sif.seq_req = 1'b0; mif.cop_mem_stall = 1'b1;
        @(negedge clk);
        chk("midrst_busy", mif.cop_mem_cen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mif.cop_mem_stall = 1'b0;
        chk("midrst_cen",   mif.cop_mem_cen, 1'b0);
        chk("midrst_ready", sif.seq_ready, 1'b1);
        chk("midrst_rsp",   sif.seq_rsp, 1'b0);
        chk("midrst_rdata", sif.seq_rdata, 128'h0);

        // Unaligned full-word lane
        clear_batch();
        b_cen = 4'b0010; b_addr[1] = 32'h202; b_ben[1] = 4'hF; b_mval[1] = 32'hE1;
        run_batch("align");

        for (int t = 0; t < 40; t++) begin
            clear_batch();
            b_cen = 4'($urandom); b_wen = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                b_addr[i] = $urandom; b_wdata[i] = $urandom; b_mval[i] = $urandom;
                b_ben[i] = 4'($urandom); b_stall[i] = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 3) == 0) b_err_lane = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                b_abort_lane = $urandom_range(0, 3);
                b_stall[b_abort_lane] = 1 + $urandom_range(0, 1);
            end
            b_ack_delay = $urandom_range(0, 2);
            run_batch("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
